invaders_ram_arbiter: RTL and testbench
=======================================

# invaders_ram_arbiter

Shares the single-port work RAM between the 8080 CPU core and a secondary host port (hiscore save/restore, debug peek/poke). The arbiter sits between the CPU core's RAM bus and the memory block. It stalls the CPU through its clock-enable input, normally only inside vertical blank, and performs bounded bursts of host accesses.

## Interface
Parameters:
- ADDR_W, 13, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 16, maximum host words per grant (>=1).
- TIMEOUT, 65535, cycles a pending host request waits outside VBlank before a forced 1-word grant.

Ports:
- Clk  in  1  system clock; one clock domain.
- Rst_n  in  1  reset, asynchronous, active-low.
- VBlank  in  1  high during vertical blank; the grant window.
- cpu_addr  in  ADDR_W  CPU RAM address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we_n  in  1  CPU write strobe, active-low.
- cpu_rdata  out  DATA_W  read data to CPU; always equals ram_rdata.
- cpu_ena  out  1  CPU clock enable; low stalls the CPU.
- hs_req  in  1  host request; a level held until hs_ack.
- hs_we  in  1  host write (1) / read (0).
- hs_addr  in  ADDR_W  host address.
- hs_wdata  in  DATA_W  host write data.
- hs_ack  out  1  one-cycle completion pulse.
- hs_rdata  out  DATA_W  host read data; valid while hs_ack is high, held until the next ack.
- ram_addr  out  ADDR_W  to the memory block.
- ram_wdata  out  DATA_W  to the memory block.
- ram_we_n  out  1  to the memory block, active-low.
- ram_rdata  in  DATA_W  RAM registered read data; 1-cycle latency from ram_addr.

## Operation
States:
- IDLE
  - cpu_ena=1; RAM mux selects the CPU (ram_* = cpu_*).
  - Go to STALL when hs_req && (VBlank || wait_cnt==TIMEOUT).
  - Latch forced = !VBlank.
- STALL
  - cpu_ena=0; mux still selects the CPU, so an in-flight CPU write lands.
  - Go to ACCESS.
- ACCESS
  - cpu_ena=0; mux selects the host: ram_addr=hs_addr, ram_wdata=hs_wdata, ram_we_n=!hs_we.
  - burst_cnt+1.
  - Go to CAPTURE.
- CAPTURE
  - cpu_ena=0; ram_addr=hs_addr, ram_we_n=1.
  - hs_rdata <= ram_rdata at the end of the cycle, for reads and writes alike.
  - Go to ACK.
- ACK
  - cpu_ena=0; hs_ack=1; mux selects the host with we_n=1.
  - Go to DECIDE.
- DECIDE
  - cpu_ena=0; we_n=1. The requester has had one edge to drop hs_req or present its next request.
  - If hs_req && !forced && VBlank && burst_cnt<MAX_BURST, go to ACCESS.
  - Otherwise clear burst_cnt and go to IDLE.

Counters and register rules:
- wait_cnt (width ceil(log2(TIMEOUT+1)))
  - Increments in IDLE while hs_req && !VBlank; saturates at TIMEOUT.
  - Clears when hs_req is low, when VBlank is high, and on entering STALL.
  - TIMEOUT=0 grants a pending request immediately, as a forced grant.
- burst_cnt (width ceil(log2(MAX_BURST+1))) never exceeds MAX_BURST.
- A forced grant always performs exactly 1 word.
- Once ACCESS is entered, the word completes and is acked even if hs_req drops or VBlank falls.
- hs_req and hs_addr/hs_wdata/hs_we must stay stable from request until ack; the arbiter does not register them.

Reset (Rst_n low, any state, asynchronous):
- State goes to IDLE with cpu_ena=1, hs_ack=0, hs_rdata=0, wait_cnt=0, burst_cnt=0, forced=0.
- The mux selects the CPU immediately.

## Timing
- Request to first ack, VBlank high: hs_req seen high in IDLE at edge N; ack is high in cycle N+4 (STALL, ACCESS, CAPTURE, ACK).
- Burst word spacing: 4 cycles ack to ack (DECIDE, ACCESS, CAPTURE, ACK).
- CPU stall per grant: 1 + 4*words cycles.
  - Worst case is 1 + 4*MAX_BURST = 65 cycles with defaults.
  - A forced grant stalls 5 cycles.
- cpu_ena, ram_* and mux selection are combinational decodes of registered state.
- hs_ack and hs_rdata are registered.
- VBlank is sampled only in IDLE and DECIDE.

## Test plan
- Read in VBlank: RAM[0x0123]=0x5A, VBlank=1, hs_req read at 0x0123 -> cpu_ena low for exactly 5 cycles, hs_ack one pulse 4 cycles after the request, hs_rdata=0x5A, CPU bus restored in IDLE.
- Write then CPU read: host writes 0xA5 to 0x1FFF in VBlank, then CPU reads 0x1FFF -> cpu_rdata=0xA5; a CPU write held across STALL lands before the host word.
- Burst limit: MAX_BURST=16, hs_req held continuously for 20 words in VBlank -> 16 acks spaced 4 cycles, return to IDLE with cpu_ena=1 for at least 1 cycle, then a new STALL with the remaining 4 words.
- Forced grant: TIMEOUT=100, VBlank=0, hs_req held -> grant at wait_cnt=100 (STALL at cycle 101), 1 word only, back to IDLE, next word after a further 100 waiting cycles.
- VBlank falls mid-burst: VBlank drops during word 3's ACCESS -> word 3 completes and acks, DECIDE returns to IDLE, and the remaining words wait.
- Reset mid-burst: Rst_n low during CAPTURE -> same cycle cpu_ena=1, hs_ack=0, mux selects the CPU; after release, IDLE with counters at 0.

Source files
------------

// File: rtl/invaders_ram_arbiter_if.sv
// rtl/invaders_ram_arbiter_if.sv - host peek/poke port bundle for the work-RAM arbiter
interface invaders_ram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) ();
  logic              hs_req;
  logic              hs_we;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_wdata;
  logic              hs_ack;
  logic [DATA_W-1:0] hs_rdata;

  // Requester side (hiscore save/restore, debug access)
  modport master (
    output hs_req, hs_we, hs_addr, hs_wdata,
    input  hs_ack, hs_rdata
  );

  // Arbiter side
  modport slave (
    input  hs_req, hs_we, hs_addr, hs_wdata,
    output hs_ack, hs_rdata
  );
endinterface

// File: rtl/invaders_ram_arbiter.sv
// rtl/invaders_ram_arbiter.sv - shares the 8080 work RAM with a host port, stalling the CPU in VBlank
module invaders_ram_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                VBlank,
  // CPU core RAM bus
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_we_n,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ena,
  // Host port
  invaders_ram_arbiter_if.slave hs,
  // Memory block
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we_n,
  input  logic [DATA_W-1:0]   ram_rdata
);

  // A zero TIMEOUT still needs a one-bit counter so the compare is legal.
  localparam int WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [WAIT_W-1:0]  TIMEOUT_V   = WAIT_W'(TIMEOUT);
  localparam logic [BURST_W-1:0] MAX_BURST_V = BURST_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STALL   = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_ACK     = 3'd4,
    S_DECIDE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic                forced_q, forced_d;
  logic                hs_ack_q, hs_ack_d;
  logic [DATA_W-1:0]   hs_rdata_q, hs_rdata_d;

  logic grant_req;
  logic burst_more;

  // A pending request is granted in VBlank, or outside it once it has waited TIMEOUT cycles.
  assign grant_req  = hs.hs_req && (VBlank || (wait_cnt_q == TIMEOUT_V));
  // Another word may follow only for a non-forced grant still inside VBlank with burst budget left.
  assign burst_more = hs.hs_req && !forced_q && VBlank && (burst_cnt_q < MAX_BURST_V);

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (grant_req) state_d = S_STALL;
      S_STALL:   state_d = S_ACCESS;
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ACK;
      S_ACK:     state_d = S_DECIDE;
      S_DECIDE:  state_d = burst_more ? S_ACCESS : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM output decode: CPU owns the RAM in IDLE and STALL, the host everywhere else
  always_comb begin
    cpu_ena   = 1'b0;
    ram_addr  = hs.hs_addr;
    ram_wdata = hs.hs_wdata;
    ram_we_n  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cpu_ena   = 1'b1;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we_n  = cpu_we_n;
      end
      // CPU is frozen but its bus stays on the RAM so a write already in flight lands.
      S_STALL: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we_n  = cpu_we_n;
      end
      S_ACCESS: begin
        ram_we_n  = !hs.hs_we;
      end
      default: begin
        ram_we_n  = 1'b1;
      end
    endcase
  end

  // Wait/burst counters, forced-grant flag and host response next values
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    forced_d    = forced_q;
    hs_ack_d    = (state_q == S_CAPTURE);
    hs_rdata_d  = hs_rdata_q;

    // The timeout only measures an uninterrupted wait outside VBlank.
    if (!hs.hs_req || VBlank) begin
      wait_cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      if (grant_req) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q < TIMEOUT_V) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    if ((state_q == S_IDLE) && grant_req) begin
      forced_d = !VBlank;
    end

    if ((state_q == S_ACCESS) && (burst_cnt_q < MAX_BURST_V)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end else if ((state_q == S_DECIDE) && !burst_more) begin
      burst_cnt_d = '0;
    end

    // RAM data for the host word is valid one cycle after ACCESS presented the address.
    if (state_q == S_CAPTURE) begin
      hs_rdata_d = ram_rdata;
    end
  end

  // Counter and host response registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      forced_q    <= 1'b0;
      hs_ack_q    <= 1'b0;
      hs_rdata_q  <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      forced_q    <= forced_d;
      hs_ack_q    <= hs_ack_d;
      hs_rdata_q  <= hs_rdata_d;
    end
  end

  assign cpu_rdata   = ram_rdata;
  assign hs.hs_ack   = hs_ack_q;
  assign hs.hs_rdata = hs_rdata_q;

endmodule

// File: tb/tb_invaders_ram_arbiter.sv
// tb/tb_invaders_ram_arbiter.sv - scoreboard bench for invaders_ram_arbiter
module tb_invaders_ram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int TO = 100;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          VBlank = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_we_n = 1'b1;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we_n;
  logic [DW-1:0] ram_rdata;

  invaders_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) hs_if ();

  invaders_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .VBlank(VBlank),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we_n(cpu_we_n),
    .cpu_rdata(cpu_rdata), .cpu_ena(cpu_ena),
    .hs(hs_if.slave),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we_n(ram_we_n),
    .ram_rdata(ram_rdata)
  );

  always #5 Clk = ~Clk;

  // Work RAM model with a backdoor preload port
  logic [DW-1:0] mem [0:8191];
  logic [DW-1:0] shadow [0:8191];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge Clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!ram_we_n) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed { logic rd; logic [DW-1:0] d; } exp_t;
  exp_t sb[$];
  int   ack_cycles[$];

  int checks = 0;
  int failures = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pops on ack, single-pulse check, stall cycle counting
  int   ack_count = 0;
  int   stall_cnt = 0;
  logic prev_ack = 1'b0;
  always @(negedge Clk) begin
    if (hs_if.hs_ack) begin
      expect_eq("ack_single_pulse", prev_ack, 0);
      expect_eq("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd) expect_eq("hs_rdata", hs_if.hs_rdata, e.d);
      end
      ack_count <= ack_count + 1;
    end
    if (!cpu_ena) stall_cnt <= stall_cnt + 1;
    prev_ack <= hs_if.hs_ack;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1; shadow[a] = d;
    @(posedge Clk); #1;
    bd_we = 1'b0;
  endtask

  // One host word; returns the cycles from driving the request to the ack cycle.
  task automatic host_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit drop, output int lat);
    exp_t e;
    int t0;
    int n;
    e.rd = !we; e.d = shadow[a];
    sb.push_back(e);
    if (we) shadow[a] = d;
    hs_if.hs_we = we; hs_if.hs_addr = a; hs_if.hs_wdata = d; hs_if.hs_req = 1'b1;
    t0 = cyc; n = 0; lat = -1;
    while (n < 400) begin
      @(negedge Clk);
      n++;
      if (hs_if.hs_ack) break;
    end
    if (hs_if.hs_ack) begin
      lat = cyc - t0;
      ack_cycles.push_back(cyc);
    end else begin
      expect_eq("ack_timeout", hs_if.hs_ack, 1);
      void'(sb.pop_back());
    end
    @(posedge Clk); #1;
    if (drop) hs_if.hs_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required fewer", cyc);
    $fatal(1);
  end

  int lat, lat2, s0, a0;

  initial begin
    hs_if.hs_req = 1'b0; hs_if.hs_we = 1'b0; hs_if.hs_addr = '0; hs_if.hs_wdata = '0;
    cpu_addr = 13'h0ABC;
    repeat (2) @(posedge Clk);
    #1;
    preload(13'h0123, 8'h5A);
    preload(13'h0200, 8'h11);
    preload(13'h1FFF, 8'h00);
    for (int i = 0; i < 20; i++) preload(13'h0400 + 13'(i), 8'(i * 7 + 3));
    preload(13'h0800, 8'hC3);
    preload(13'h0801, 8'h3C);
    for (int i = 0; i < 5; i++) preload(13'h0900 + 13'(i), 8'(8'h90 + i * 3));

    // Reset state
    @(negedge Clk);
    expect_eq("rst_cpu_ena", cpu_ena, 1);
    expect_eq("rst_hs_ack", hs_if.hs_ack, 0);
    expect_eq("rst_hs_rdata", hs_if.hs_rdata, 0);
    expect_eq("rst_mux_addr", ram_addr, 13'h0ABC);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Read in VBlank
    VBlank = 1'b1;
    s0 = stall_cnt;
    host_xfer(1'b0, 13'h0123, 8'h00, 1'b1, lat);
    expect_eq("vb_read_latency", lat, 4);
    expect_eq("vb_read_data", hs_if.hs_rdata, 8'h5A);
    repeat (3) @(posedge Clk);
    #1;
    expect_eq("vb_read_stall", stall_cnt - s0, 5);
    expect_eq("vb_read_cpu_ena", cpu_ena, 1);
    expect_eq("vb_read_mux", ram_addr, 13'h0ABC);

    // Host write, then CPU read-back; CPU write held across STALL
    host_xfer(1'b1, 13'h1FFF, 8'hA5, 1'b1, lat);
    repeat (2) @(posedge Clk);
    #1;
    cpu_addr = 13'h1FFF; cpu_we_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    expect_eq("cpu_readback", cpu_rdata, 8'hA5);
    @(posedge Clk); #1;
    cpu_addr = 13'h0200; cpu_wdata = 8'h77; cpu_we_n = 1'b0;
    shadow[13'h0200] = 8'h77;
    host_xfer(1'b0, 13'h0200, 8'h00, 1'b1, lat);
    cpu_we_n = 1'b1;
    expect_eq("cpu_write_first", hs_if.hs_rdata, 8'h77);
    repeat (2) @(posedge Clk);
    #1;

    // Burst limit: 20 words held continuously
    ack_cycles.delete();
    s0 = stall_cnt;
    for (int i = 0; i < 20; i++) host_xfer(1'b0, 13'h0400 + 13'(i), 8'h00, (i == 19), lat);
    repeat (3) @(posedge Clk);
    #1;
    expect_eq("burst_acks", ack_cycles.size(), 20);
    if (ack_cycles.size() == 20)
      for (int i = 1; i < 20; i++)
        expect_eq($sformatf("burst_gap_%0d", i), ack_cycles[i] - ack_cycles[i-1], (i == 16) ? 6 : 4);
    expect_eq("burst_stall", stall_cnt - s0, 82);

    // Forced grant outside VBlank
    VBlank = 1'b0;
    ack_cycles.delete();
    s0 = stall_cnt;
    host_xfer(1'b0, 13'h0800, 8'h00, 1'b0, lat);
    host_xfer(1'b0, 13'h0801, 8'h00, 1'b1, lat2);
    expect_eq("forced_lat1", lat, 104);
    expect_eq("forced_lat2", lat2, 105);
    if (ack_cycles.size() == 2) expect_eq("forced_gap", ack_cycles[1] - ack_cycles[0], 106);
    repeat (3) @(posedge Clk);
    #1;
    expect_eq("forced_stall", stall_cnt - s0, 10);

    // VBlank falls during word 3's ACCESS
    VBlank = 1'b1;
    a0 = ack_count;
    fork
      begin
        for (int i = 0; i < 5; i++) host_xfer(1'b0, 13'h0900 + 13'(i), 8'h00, (i == 4), lat);
      end
      begin
        int seen;
        int n;
        int s1;
        int a1;
        seen = 0; n = 0;
        while (seen < 2 && n < 400) begin
          @(negedge Clk); n++;
          if (hs_if.hs_ack) seen++;
        end
        @(posedge Clk);
        @(posedge Clk); #1;
        VBlank = 1'b0;
        @(negedge Clk);
        expect_eq("vbfall_in_access", cpu_ena, 0);
        while (seen < 3 && n < 400) begin
          @(negedge Clk); n++;
          if (hs_if.hs_ack) seen++;
        end
        expect_eq("vbfall_word3_acked", seen, 3);
        @(posedge Clk);
        @(posedge Clk); #1;
        s1 = stall_cnt; a1 = ack_count;
        repeat (20) @(posedge Clk);
        #1;
        expect_eq("vbfall_idle_cpu_ena", cpu_ena, 1);
        expect_eq("vbfall_no_stall", stall_cnt - s1, 0);
        expect_eq("vbfall_no_ack", ack_count - a1, 0);
        VBlank = 1'b1;
      end
    join
    @(posedge Clk); #1;
    expect_eq("vbfall_total_acks", ack_count - a0, 5);

    // Reset during CAPTURE
    hs_if.hs_we = 1'b0; hs_if.hs_addr = 13'h0123; hs_if.hs_req = 1'b1;
    cpu_addr = 13'h0555;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    expect_eq("capture_stalled", cpu_ena, 0);
    #1;
    Rst_n = 1'b0;
    #1;
    expect_eq("rst_mid_cpu_ena", cpu_ena, 1);
    expect_eq("rst_mid_hs_ack", hs_if.hs_ack, 0);
    expect_eq("rst_mid_hs_rdata", hs_if.hs_rdata, 0);
    expect_eq("rst_mid_mux", ram_addr, 13'h0555);
    hs_if.hs_req = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    s0 = stall_cnt;
    host_xfer(1'b0, 13'h0123, 8'h00, 1'b1, lat);
    expect_eq("post_rst_latency", lat, 4);
    repeat (3) @(posedge Clk);
    #1;
    expect_eq("post_rst_stall", stall_cnt - s0, 5);

    expect_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
